mips_prog_loader: RTL and testbench
===================================

Name: mips_prog_loader

Overview:
- Boot-time program loader that sits directly upstream of MIPS32_pipeline.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words into the core's instruction/data memory through a single write port.
- Holds the core halted until the whole frame, including its checksum, has been received and verified; only then releases the core to start at PC=0.

Parameters:
- ADDR_W, 10, width of memory word address.
- MEM_DEPTH, 1024, number of 32-bit words in target memory.
- BASE_ADDR, 0, word address of the first loaded instruction.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk1 input 1: single clock. All logic is rising-edge.
- rst_n input 1: synchronous, active-low reset.
- in_data input 8: stream byte.
- in_valid input 1: byte present.
- in_ready output 1: loader can accept a byte. A transfer occurs when in_valid and in_ready are both 1.
- restart input 1: one-cycle pulse; rearms the loader from DONE or ERR.
- mem_we output 1: memory write strobe.
- mem_addr output ADDR_W: write word address.
- mem_wdata output 32: write data.
- core_run output 1: 1 releases the core (drives HALTED=0, PC=0); 0 holds it halted.
- load_done output 1: frame loaded and checksum matched.
- load_err output 1: frame rejected.

Behaviour:
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then N = {CNT_HI, CNT_LO} words of 4 bytes each (MSB first), then CSUM.
- CSUM is the 8-bit XOR of every byte after SYNC, up to but excluding CSUM.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, load_done=0, load_err=0, state=IDLE, internal checksum=0, word count=0.
- in_ready is 1 in IDLE, CNT_HI, CNT_LO, WORD and CSUM. It is 0 in DONE and ERR, and in the first cycle after reset.
- IDLE:
  - Accepted byte == SYNC_BYTE -> CNT_HI; clear checksum.
  - Any other byte is discarded; stay in IDLE.
- CNT_HI -> CNT_LO on accept. Latch the high byte and fold it into the checksum.
- CNT_LO on accept:
  - If N > MEM_DEPTH - BASE_ADDR -> ERR.
  - Else if N == 0 -> CSUM.
  - Else -> WORD with byte index 0.
- WORD:
  - Shift accepted bytes into the 32-bit assembly register; fold each into the checksum.
  - On the 4th byte, in the next cycle: mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = BASE_ADDR + word index.
  - Word index increments after each write. After word N-1 -> CSUM.
  - A new byte may be accepted in the same cycle as a write strobe; throughput is one byte per cycle.
- CSUM on accept:
  - Byte == running checksum -> DONE.
  - Otherwise -> ERR.
- DONE: load_done=1 and core_run=1, registered, asserted one cycle after the CSUM byte is accepted and held.
- ERR: load_err=1, core_run=0, held. Words already written stay in memory; core_run never rises.
- restart in DONE or ERR: next cycle returns to IDLE and clears core_run, load_done, load_err, word index and checksum. restart in any other state is ignored.
- in_valid gaps are allowed in every state; state and byte index are frozen while no transfer occurs.
- rst_n low in any cycle, including mid-word or during a pending write strobe:
  - Next state is the reset state.
  - The pending mem_we is suppressed.
  - A partially assembled word is never written.
- mem_addr wraps modulo 2^ADDR_W. It cannot exceed MEM_DEPTH-1 because of the N bound check.

Test Plan:
- Two-word frame A5 00 02 28 01 00 78 FC 00 00 00 AF, in_valid continuous -> mem_we pulses with (addr 0, 0x28010078) then (addr 1, 0xFC000000); load_done=1 and core_run=1 one cycle after AF is accepted.
- Same frame with final byte AE -> both writes still occur; load_err=1, core_run stays 0. Then restart pulse -> IDLE, in_ready=1, all flags 0.
- Leading garbage 00 FF 12, then the valid frame with in_valid toggling every other cycle -> garbage ignored; identical writes and load_done outcome.
- Zero-length frame A5 00 00 00 -> no mem_we; load_done=1.
- Oversize count A5 04 01 (N=1025, MEM_DEPTH=1024) -> load_err=1 one cycle after CNT_LO; no writes; in_ready=0.
- rst_n low after the 2nd byte of word 1 -> no write for word 1; all outputs at reset values. A fresh frame then loads correctly starting at addr 0.

Source files
------------

// File: rtl/mips_prog_loader_if.sv
// Byte-stream, memory write port and status bundle between the loader and its neighbours.
// Latency: none, wires only.
// Backpressure: in_ready from the loader throttles the byte stream; the write port has none.
//
// Signals: in_data/in_valid/in_ready (byte stream), restart (rearm pulse),
//          mem_we/mem_addr/mem_wdata (word write port), core_run/load_done/load_err (status).
// Modports: master = stream source / memory + core side, slave = the loader.
interface mips_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic              load_done;
    logic              load_err;

    modport master (
        output in_data, in_valid, restart,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, load_err
    );

    modport slave (
        input  in_data, in_valid, restart,
        output in_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, load_err
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot loader: parses SYNC/CNT/words/CSUM frames, writes big-endian words, releases the core on a good checksum.
// Latency: write strobe one cycle after a word's 4th byte; done/err one cycle after the deciding byte.
// Backpressure: in_ready high while parsing a frame, low in DONE/ERR and in the first cycle out of reset.
//
// Ports: clk1 (rising-edge clock), rst_n (synchronous, active-low reset),
//        bus (slave side of mips_prog_loader_if: byte stream in, restart in,
//             memory write port out, core_run/load_done/load_err out).
module mips_prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         MEM_DEPTH = 1024,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst_n,
    mips_prog_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_CNT_LO = 3'd2;
    localparam logic [2:0] S_WORD   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Largest word count that still fits between BASE_ADDR and the end of memory.
    localparam int unsigned LIMIT = MEM_DEPTH - BASE_ADDR;

    logic [2:0]        state;
    logic              armed;      // low for the first cycle after reset so in_ready starts at 0
    logic [7:0]        cnt_hi;
    logic [15:0]       n_words;
    logic [15:0]       widx;
    logic [1:0]        bidx;
    logic [23:0]       asm_q;      // first three bytes of the word being assembled
    logic [7:0]        csum;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              core_run_q;
    logic              load_done_q;
    logic              load_err_q;

    logic        accept;
    logic [15:0] cnt_full;
    logic [31:0] word_full;

    assign bus.in_ready = armed && (state == S_IDLE || state == S_CNT_HI || state == S_CNT_LO ||
                                    state == S_WORD || state == S_CSUM);
    assign accept    = bus.in_valid && bus.in_ready;
    assign cnt_full  = {cnt_hi, bus.in_data};
    assign word_full = {asm_q, bus.in_data};

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.core_run  = core_run_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            // Reset wins over everything, including a strobe that would fire this edge,
            // so a half-built or just-completed word is dropped.
            state       <= S_IDLE;
            armed       <= 1'b0;
            cnt_hi      <= 8'd0;
            n_words     <= 16'd0;
            widx        <= 16'd0;
            bidx        <= 2'd0;
            asm_q       <= 24'd0;
            csum        <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            core_run_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            armed    <= 1'b1;
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && bus.in_data == SYNC_BYTE) begin
                        state <= S_CNT_HI;
                        csum  <= 8'd0;
                        widx  <= 16'd0;
                        bidx  <= 2'd0;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        cnt_hi <= bus.in_data;
                        csum   <= csum ^ bus.in_data;
                        state  <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        csum    <= csum ^ bus.in_data;
                        n_words <= cnt_full;
                        bidx    <= 2'd0;
                        if ({16'd0, cnt_full} > LIMIT) begin
                            state      <= S_ERR;
                            load_err_q <= 1'b1;
                        end else if (cnt_full == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    if (accept) begin
                        csum  <= csum ^ bus.in_data;
                        asm_q <= word_full[23:0];
                        bidx  <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= word_full;
                            // Truncation gives the modulo-2^ADDR_W wrap.
                            mem_addr_q  <= ADDR_W'(BASE_ADDR + int'(widx));
                            widx        <= widx + 16'd1;
                            if ((widx + 16'd1) == n_words) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (bus.in_data == csum) begin
                            state       <= S_DONE;
                            load_done_q <= 1'b1;
                            core_run_q  <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.restart) begin
                        state       <= S_IDLE;
                        core_run_q  <= 1'b0;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                        widx        <= 16'd0;
                        csum        <= 8'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// Testbench for mips_prog_loader: table vectors, reset corner cases, random frames vs a frame-parsing model.
// Latency: n/a.
// Backpressure: stimulus holds each byte until the loader accepts it.
module tb_mips_prog_loader;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    mips_prog_loader_if #(.ADDR_W(10)) bus();

    mips_prog_loader #(
        .ADDR_W(10), .MEM_DEPTH(1024), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim[$];
    logic [9:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    typedef struct {
        logic [0:15][7:0] b;
        int               len;
        int               gap;      // 0 continuous, 1 toggling, 2 random
        int               outcome;  // 1 done, 2 err
        int               nw;
        logic [31:0]      w0;
        logic [31:0]      w1;
    } vec_t;

    vec_t vecs[5];

    // Capture every write strobe away from the active edge.
    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input int gap_mode);
        int  i = 0;
        int  cyc = 0;
        bit  xfer;
        while (i < stim.size() && cyc < 20000) begin
            bus.in_data = stim[i];
            case (gap_mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            xfer = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (xfer) i++;
        end
        bus.in_valid = 1'b0;
        check("send_bytes_accepted", 32'(i), 32'(stim.size()));
    endtask

    task automatic check_flags(input string tag, input int outcome);
        check({tag, "_load_done"}, 32'(bus.load_done), 32'(outcome == 1));
        check({tag, "_load_err"},  32'(bus.load_err),  32'(outcome == 2));
        check({tag, "_core_run"},  32'(bus.core_run),  32'(outcome == 1));
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(got_addr[k]), 32'(exp_addr[k]));
            check($sformatf("%s_data%0d", tag, k), got_data[k], exp_data[k]);
        end
    endtask

    task automatic restart_pulse(input string tag);
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check({tag, "_rst_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_rst_load_done"}, 32'(bus.load_done), 32'd0);
        check({tag, "_rst_load_err"},  32'(bus.load_err),  32'd0);
        check({tag, "_rst_core_run"},  32'(bus.core_run),  32'd0);
    endtask

    // Full frame: stream it, check flags one cycle after the last byte, then writes, then rearm.
    task automatic run_frame(input string tag, input int gap_mode, input int outcome);
        got_addr.delete();
        got_data.delete();
        send(gap_mode);
        check_flags(tag, outcome);
        step();
        step();
        check_writes(tag);
        restart_pulse(tag);
    endtask

    task automatic run_vec(input int v);
        stim.delete();
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < vecs[v].len; k++) stim.push_back(vecs[v].b[k]);
        if (vecs[v].nw >= 1) begin exp_addr.push_back(10'd0); exp_data.push_back(vecs[v].w0); end
        if (vecs[v].nw >= 2) begin exp_addr.push_back(10'd1); exp_data.push_back(vecs[v].w1); end
        run_frame($sformatf("vec%0d", v), vecs[v].gap, vecs[v].outcome);
    endtask

    // Reference: parse the byte list as a frame and list the writes and outcome it implies.
    task automatic model(output int outcome);
        int i = 0;
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        outcome = 0;
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        if (i + 2 >= stim.size()) return;
        n = int'({stim[i+1], stim[i+2]});
        if (n > 1024) begin
            outcome = 2;
            return;
        end
        x = stim[i+1] ^ stim[i+2];
        for (int w = 0; w < n; w++) begin
            int j = i + 3 + 4 * w;
            exp_addr.push_back(10'(w));
            exp_data.push_back({stim[j], stim[j+1], stim[j+2], stim[j+3]});
            x = x ^ stim[j] ^ stim[j+1] ^ stim[j+2] ^ stim[j+3];
        end
        outcome = (stim[i + 3 + 4 * n] == x) ? 1 : 2;
    endtask

    task automatic gen_frame(input int n, input bit corrupt, input int garbage);
        logic [7:0] b;
        logic [7:0] x = 8'd0;
        stim.delete();
        for (int g = 0; g < garbage; g++) begin
            b = 8'hA5;
            while (b == 8'hA5) b = 8'($urandom_range(0, 255));
            stim.push_back(b);
        end
        stim.push_back(8'hA5);
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        if (n > 1024) return;
        x = 8'(n >> 8) ^ 8'(n);
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom_range(0, 255));
            stim.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        stim.push_back(x);
    endtask

    initial begin
        int outcome;
        int n;

        vecs[0] = '{b: {8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78, 8'hFC,
                        8'h00, 8'h00, 8'h00, 8'hAF, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 12, gap: 0, outcome: 1, nw: 2, w0: 32'h28010078, w1: 32'hFC000000};
        vecs[1] = '{b: {8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78, 8'hFC,
                        8'h00, 8'h00, 8'h00, 8'hAE, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 12, gap: 0, outcome: 2, nw: 2, w0: 32'h28010078, w1: 32'hFC000000};
        vecs[2] = '{b: {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h02, 8'h28, 8'h01,
                        8'h00, 8'h78, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hAF, 8'h00},
                    len: 15, gap: 1, outcome: 1, nw: 2, w0: 32'h28010078, w1: 32'hFC000000};
        vecs[3] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 4, gap: 0, outcome: 1, nw: 0, w0: 32'h0, w1: 32'h0};
        vecs[4] = '{b: {8'hA5, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    len: 3, gap: 0, outcome: 2, nw: 0, w0: 32'h0, w1: 32'h0};

        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        rst_n = 1'b1;

        // First cycle out of reset.
        check("reset_in_ready",  32'(bus.in_ready),  32'd0);
        check("reset_mem_we",    32'(bus.mem_we),    32'd0);
        check("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("reset_mem_wdata", bus.mem_wdata,      32'd0);
        check("reset_core_run",  32'(bus.core_run),  32'd0);
        check("reset_load_done", 32'(bus.load_done), 32'd0);
        check("reset_load_err",  32'(bus.load_err),  32'd0);
        step();
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Reset after the 2nd byte of word 1: only word 0 may reach memory.
        stim.delete();
        got_addr.delete();
        got_data.delete();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78, 8'hFC, 8'h00};
        send(0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_mem_we",    32'(bus.mem_we),    32'd0);
        check("midrst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("midrst_mem_wdata", bus.mem_wdata,      32'd0);
        check("midrst_load_done", 32'(bus.load_done), 32'd0);
        check("midrst_load_err",  32'(bus.load_err),  32'd0);
        check("midrst_core_run",  32'(bus.core_run),  32'd0);
        step();
        step();
        check("midrst_nwrites", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) check("midrst_word0", got_data[0], 32'h28010078);
        check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
        run_vec(0);

        // Reset on the very edge that accepts a word's last byte: the strobe must not appear.
        stim.delete();
        got_addr.delete();
        got_data.delete();
        stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send(0);
        bus.in_data  = 8'h44;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        check("pendrst_mem_we",    32'(bus.mem_we), 32'd0);
        check("pendrst_mem_wdata", bus.mem_wdata,   32'd0);
        step();
        step();
        check("pendrst_nwrites", 32'(got_addr.size()), 32'd0);

        // Random frames against the model.
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(1025, 1100));
            else                           n = int'($urandom_range(0, 5));
            gen_frame(n, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            model(outcome);
            run_frame($sformatf("rnd%0d", r), 2, outcome);
        end

        // Largest legal frame fills memory exactly.
        gen_frame(1024, 1'b0, 0);
        model(outcome);
        run_frame("full", 0, outcome);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
